// File: rtl/piano_pkg.sv
// piano_pkg: shared constants for the electronic piano.
//   - note frequency table (middle octave) and half_period() helper
//   - octave encodings, note selection struct
//   - active-low 7-seg glyphs {dp,g,f,e,d,c,b,a}
//   - demo song ROM (only referenced when DEMO_SONG_EN is defined)
package piano_pkg;

  typedef enum logic [1:0] {
    OCT_OFF  = 2'b00,
    OCT_LOW  = 2'b01,
    OCT_MID  = 2'b10,
    OCT_HIGH = 2'b11
  } octave_e;

  // Active note: oct = 0 or note = 0 means silence.
  typedef struct packed {
    logic [1:0] oct;
    logic [2:0] note;
  } note_t;

  localparam int unsigned NOTE_HZ [1:7] = '{262, 294, 330, 349, 392, 440, 494};

  // floor(clk / (2 * f_oct)) with f_oct = f * {0.5, 1, 2}; the 0.5 factor
  // cancels the 2, which keeps odd middle frequencies (349 Hz) exact.
  function automatic int unsigned half_period(input int unsigned clk_hz,
                                              input int unsigned note,
                                              input int unsigned oct);
    int unsigned f;
    f = NOTE_HZ[note];
    case (oct)
      1:       return clk_hz / f;
      2:       return clk_hz / (2 * f);
      default: return clk_hz / (4 * f);
    endcase
  endfunction

  // Index 0..7 -> glyph for digit 0..7.
  localparam logic [7:0] SEG_DIGIT [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0,
                                           8'h99, 8'h92, 8'h82, 8'hF8};
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Twinkle twinkle, middle octave, {oct, note}; all-zero entries are rests.
  localparam logic [4:0] DEMO_ROM [16] = '{
    5'b10_001, 5'b10_001, 5'b10_101, 5'b10_101,
    5'b10_110, 5'b10_110, 5'b10_101, 5'b00_000,
    5'b10_100, 5'b10_100, 5'b10_011, 5'b10_011,
    5'b10_010, 5'b10_010, 5'b10_001, 5'b00_000
  };

endpackage

// File: rtl/piano_tone_gen.sv
// piano_tone_gen: square-wave generator for one note/octave.
//   clk, rst  : clock, synchronous active-high reset
//   note      : 1..7 (0 = silent)
//   octave    : 1..3 (0 = silent)
//   beep      : square wave, toggles every half_period cycles
// A change of note/octave restarts the period with beep low.
module piano_tone_gen
  import piano_pkg::*;
#(
  parameter int CLK_HZ = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] note,
  input  logic [1:0] octave,
  output logic       beep
);

  // Longest half period is the lowest note in the low octave.
  localparam int CW = $clog2(half_period(CLK_HZ, 1, 1) + 1);

  // Constant half-period table; each entry folds at elaboration.
  logic [CW-1:0] hp_tab [8][4];
  for (genvar n = 0; n < 8; n++) begin : g_note
    for (genvar o = 0; o < 4; o++) begin : g_oct
      if (n == 0 || o == 0) begin : g_off
        assign hp_tab[n][o] = '0;
      end else begin : g_on
        assign hp_tab[n][o] = CW'(half_period(CLK_HZ, n, o));
      end
    end
  end

  logic [CW-1:0] cnt, hp;
  logic [4:0]    prev;
  logic          silent;

  assign hp     = hp_tab[note][octave];
  assign silent = (note == 3'd0) || (octave == 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      beep <= 1'b0;
      prev <= '0;
    end else begin
      prev <= {note, octave};
      if (silent || ({note, octave} != prev)) begin
        cnt  <= '0;
        beep <= 1'b0;
      end else if (cnt == hp - 1'b1) begin
        cnt  <= '0;
        beep <= ~beep;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/electronic_piano.sv
// electronic_piano: 7-key, 3-octave piano top level.
//   sysclk, rst : clock, synchronous active-high reset
//   tone        : octave select (00 silent, 01 low, 10 mid, 11 high)
//   yinfu       : note keys do..si, lowest set bit wins
//   switch      : 0 free play, 1 demo song (silence unless DEMO_SONG_EN)
//   led_row     : dot-matrix row select, active-low
//   Gled_col    : green columns, one-hot note
//   Rled_col    : red column 7 lit on rows below the octave number
//   SMG, SMG_CS : 7-seg segments / digit select, both active-low
//   BEEP        : buzzer square wave
// Build option: define DEMO_SONG_EN to play the ROM song when switch = 1.
module electronic_piano
  import piano_pkg::*;
#(
  parameter int CLK_HZ  = 10_000_000,
`ifdef DEMO_SONG_EN
  parameter int DEMO_MS = 250,
`endif
  parameter int SCAN_HZ = 1_000
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic [1:0] tone,
  input  logic [6:0] yinfu,
  input  logic       switch,
  output logic [7:0] led_row,
  output logic [7:0] Gled_col,
  output logic [7:0] Rled_col,
  output logic [7:0] SMG,
  output logic [7:0] SMG_CS,
  output logic       BEEP
);

  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int SW       = $clog2(SCAN_DIV);

  // Two-flop input synchronizer.
  logic [1:0] tone_s1, tone_s2;
  logic [6:0] yinfu_s1, yinfu_s2;
  logic       sw_s1, sw_s2;

  always_ff @(posedge sysclk) begin
    if (rst) begin
      {tone_s1, tone_s2}   <= '0;
      {yinfu_s1, yinfu_s2} <= '0;
      {sw_s1, sw_s2}       <= '0;
    end else begin
      tone_s1  <= tone;   tone_s2  <= tone_s1;
      yinfu_s1 <= yinfu;  yinfu_s2 <= yinfu_s1;
      sw_s1    <= switch; sw_s2    <= sw_s1;
    end
  end

  // Key decode: scan high to low so the lowest pressed key is written last.
  note_t key_sel, sel;
  always_comb begin
    key_sel = '0;
    for (int i = 6; i >= 0; i--)
      if (yinfu_s2[i]) key_sel.note = 3'(i + 1);
    if (key_sel.note != 3'd0 && tone_s2 != OCT_OFF) key_sel.oct = tone_s2;
    else                                             key_sel     = '0;
  end

`ifdef DEMO_SONG_EN
  localparam int DEMO_DIV = (CLK_HZ / 1000) * DEMO_MS;
  localparam int DW       = $clog2(DEMO_DIV);

  logic [DW-1:0] demo_cnt;
  logic [3:0]    demo_idx;

  // Song restarts from entry 0 each time demo mode is entered.
  always_ff @(posedge sysclk) begin
    if (rst || !sw_s2) begin
      demo_cnt <= '0;
      demo_idx <= '0;
    end else if (demo_cnt == DW'(DEMO_DIV - 1)) begin
      demo_cnt <= '0;
      demo_idx <= demo_idx + 1'b1;
    end else begin
      demo_cnt <= demo_cnt + 1'b1;
    end
  end

  assign sel = sw_s2 ? note_t'(DEMO_ROM[demo_idx]) : key_sel;
`else
  assign sel = sw_s2 ? note_t'('0) : key_sel;
`endif

  logic silent;
  assign silent = (sel.note == 3'd0) || (sel.oct == 2'd0);

  piano_tone_gen #(.CLK_HZ(CLK_HZ)) u_tone (
    .clk    (sysclk),
    .rst    (rst),
    .note   (silent ? 3'd0 : sel.note),
    .octave (silent ? 2'd0 : sel.oct),
    .beep   (BEEP)
  );

  // Shared row/digit scan.
  logic [SW-1:0] scan_cnt;
  logic [2:0]    scan_idx;

  always_ff @(posedge sysclk) begin
    if (rst) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      scan_idx <= scan_idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  logic [7:0] seg_next;
  always_comb begin
    seg_next = SEG_BLANK;
    case (scan_idx)
      3'd0:    seg_next = silent ? SEG_DASH : SEG_DIGIT[sel.note];
      3'd1:    seg_next = silent ? SEG_DASH : SEG_DIGIT[{1'b0, sel.oct}];
      default: seg_next = SEG_BLANK;
    endcase
  end

  // Display outputs are registered so reset values are exact.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      led_row  <= 8'hFF;
      Gled_col <= 8'h00;
      Rled_col <= 8'h00;
      SMG      <= 8'hFF;
      SMG_CS   <= 8'hFE;
    end else begin
      led_row  <= ~(8'b1 << scan_idx);
      Gled_col <= silent ? 8'h00 : (8'b1 << (sel.note - 3'd1));
      Rled_col <= {(!silent && (scan_idx < {1'b0, sel.oct})), 7'b0};
      SMG      <= seg_next;
      SMG_CS   <= ~(8'b1 << scan_idx);
    end
  end

endmodule

// File: tb/tb_electronic_piano.sv
module tb_electronic_piano;

  localparam int CLK_HZ   = 10_000_000;
  localparam int SCAN_DIV = 10_000;

  logic       sysclk = 1'b0;
  logic       rst    = 1'b1;
  logic [1:0] tone   = '0;
  logic [6:0] yinfu  = '0;
  logic       switch = 1'b0;
  logic [7:0] led_row, Gled_col, Rled_col, SMG, SMG_CS;
  logic       BEEP;

  int n_checks = 0;
  int n_fail   = 0;
  int edges    = 0;
  int exp_note = 0;
  int exp_oct  = 0;

  int          note_f [7]  = '{262, 294, 330, 349, 392, 440, 494};
  logic [7:0]  glyph  [8]  = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};

  always #5 sysclk = ~sysclk;

  electronic_piano dut (
    .sysclk(sysclk), .rst(rst), .tone(tone), .yinfu(yinfu), .switch(switch),
    .led_row(led_row), .Gled_col(Gled_col), .Rled_col(Rled_col),
    .SMG(SMG), .SMG_CS(SMG_CS), .BEEP(BEEP)
  );

  // Edges since the last reset edge.
  always @(posedge sysclk) if (rst) edges <= 0; else edges <= edges + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: lowest pressed key wins; silence if no key, octave 0 or demo switch.
  function automatic void model(input logic [1:0] t, input logic [6:0] y, input logic sw,
                                output int note, output int oct);
    logic [6:0] lo;
    lo = y & (~y + 7'd1);
    if (sw || t == 2'd0 || y == 7'd0) begin
      note = 0; oct = 0;
    end else begin
      note = $clog2(lo) + 1; oct = t;
    end
  endfunction

  // floor(CLK / (2 * f * 2^(oct-2))) = CLK / (f * 2^(oct-1))
  function automatic int exp_hp(input int note, input int oct);
    return CLK_HZ / (note_f[note-1] * (1 << (oct - 1)));
  endfunction

  task automatic check_disp(input string tag);
    int r;
    logic [7:0] row_e, g_e, r_e, seg_e;
    r     = ((edges - 1) / SCAN_DIV) % 8;
    row_e = ~(8'b1 << r);
    g_e   = (exp_note == 0) ? 8'h00 : (8'b1 << (exp_note - 1));
    r_e   = (exp_note != 0 && r < exp_oct) ? 8'h80 : 8'h00;
    if (r == 0)      seg_e = (exp_note == 0) ? 8'hBF : glyph[exp_note];
    else if (r == 1) seg_e = (exp_note == 0) ? 8'hBF : glyph[exp_oct];
    else             seg_e = 8'hFF;
    check({tag, "_row"}, led_row,  row_e);
    check({tag, "_cs"},  SMG_CS,   row_e);
    check({tag, "_grn"}, Gled_col, g_e);
    check({tag, "_red"}, Rled_col, r_e);
    check({tag, "_seg"}, SMG,      seg_e);
  endtask

  task automatic apply(input logic [1:0] t, input logic [6:0] y, input logic sw);
    @(negedge sysclk);
    tone = t; yinfu = y; switch = sw;
    model(t, y, sw, exp_note, exp_oct);
  endtask

  // Edges from input change to first BEEP rise = 3 (sync + restart) + half period.
  task automatic measure(input string tag);
    int hp, n;
    bit seen;
    hp = exp_hp(exp_note, exp_oct);
    n = 0; seen = 0;
    while (!seen && n < hp + 200) begin
      @(posedge sysclk); #1;
      n++;
      if (n == 3) check({tag, "_clr"}, BEEP, 1'b0);
      if (n % 1000 == 0) check_disp(tag);
      if (n >= 3 && BEEP) seen = 1;
    end
    check({tag, "_hp"}, n, hp + 3);
  endtask

  task automatic hold_silent(input string tag, input int cycles);
    for (int i = 1; i <= cycles; i++) begin
      @(posedge sysclk); #1;
      if (i >= 3 && (i % 50 == 0 || i == cycles)) check({tag, "_beep"}, BEEP, 1'b0);
      if (i % 500 == 0 || i == cycles) check_disp(tag);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_beep"}, BEEP,     1'b0);
    check({tag, "_row"},  led_row,  8'hFF);
    check({tag, "_grn"},  Gled_col, 8'h00);
    check({tag, "_red"},  Rled_col, 8'h00);
    check({tag, "_seg"},  SMG,      8'hFF);
    check({tag, "_cs"},   SMG_CS,   8'hFE);
  endtask

  initial begin
    // Reset held across one edge.
    @(posedge sysclk); #1;
    check_reset("rst");
    @(negedge sysclk); rst = 1'b0;
    @(posedge sysclk); #1;
    check_disp("post_rst");

    // la, low octave: 220 Hz.
    apply(2'b01, 7'b0100000, 1'b0);
    measure("la_low");
    check_disp("la_low_end");

    // Same key, high octave: period restarts.
    apply(2'b11, 7'b0100000, 1'b0);
    measure("la_high");

    // No key pressed.
    apply(2'b01, 7'b0000000, 1'b0);
    hold_silent("nokey", 2000);

    // re, middle octave.
    apply(2'b10, 7'b0000010, 1'b0);
    measure("re_mid");

    // Two keys: lower one (re) wins.
    apply(2'b10, 7'b0100010, 1'b0);
    repeat (5) @(posedge sysclk);
    #1;
    check_disp("multi");

`ifndef DEMO_SONG_EN
    // Demo switch without the song build forces silence.
    apply(2'b10, 7'b0100000, 1'b1);
    hold_silent("switch", 200);
`endif

    // Random key patterns in the high octave.
    for (int k = 0; k < 3; k++) begin
      apply(2'b00, 7'b0, 1'b0);
      hold_silent("gap", 10);
      apply(2'b11, 7'($urandom_range(1, 127)), 1'b0);
      measure("rand");
    end

    // Run past a full scan cycle so row/digit wrap 7 -> 0 is observed.
    while (edges < 80_500) begin
      @(posedge sysclk); #1;
      if (edges % 1000 == 1) check_disp("scan");
    end

    // Reset in the middle of a tone and scan.
    @(negedge sysclk); rst = 1'b1;
    @(posedge sysclk); #1;
    check_reset("mid_rst");
    @(negedge sysclk); rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
